// File: rtl/cdb_arbiter_if.sv
// Result handshakes from the ALU and load/store buffer into the CDB arbiter,
// plus the registered CDB broadcast and the sticky NULL-tag flag.
interface cdb_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  alu_valid_in;
  logic [WORD_WIDTH-1:0] alu_result_in;
  logic [TAG_WIDTH-1:0]  alu_tag_in;
  logic                  alu_ready_out;

  logic                  lsb_valid_in;
  logic [WORD_WIDTH-1:0] lsb_result_in;
  logic [TAG_WIDTH-1:0]  lsb_tag_in;
  logic                  lsb_ready_out;

  logic                  cdb_valid_out;
  logic [WORD_WIDTH-1:0] cdb_result_out;
  logic [TAG_WIDTH-1:0]  cdb_tag_out;
  logic                  cdb_src_out;
  logic                  err_null_tag_out;

  // Arbiter side.
  modport slave (
    input  alu_valid_in, alu_result_in, alu_tag_in,
    input  lsb_valid_in, lsb_result_in, lsb_tag_in,
    output alu_ready_out, lsb_ready_out,
    output cdb_valid_out, cdb_result_out, cdb_tag_out, cdb_src_out,
    output err_null_tag_out
  );

  // Producer / snooper side.
  modport master (
    output alu_valid_in, alu_result_in, alu_tag_in,
    output lsb_valid_in, lsb_result_in, lsb_tag_in,
    input  alu_ready_out, lsb_ready_out,
    input  cdb_valid_out, cdb_result_out, cdb_tag_out, cdb_src_out,
    input  err_null_tag_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB's single CDB broadcast port between the
// ALU and the load/store buffer; each producer feeds a one-entry holding register.
module cdb_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // Handshake: a result moves into its holding register at the rising edge
  // where valid and ready are both 1. Ready never looks at valid; the producer
  // keeps valid/result/tag stable until that edge. A held entry may drain and
  // refill at the same edge, so ready stays high while the entry is granted.

  logic                  alu_hv_q, lsb_hv_q;
  logic [WORD_WIDTH-1:0] alu_data_q, lsb_data_q;
  logic [TAG_WIDTH-1:0]  alu_tag_q, lsb_tag_q;
  src_e                  last_q;

  logic                  cdb_valid_q;
  logic [WORD_WIDTH-1:0] cdb_result_q;
  logic [TAG_WIDTH-1:0]  cdb_tag_q;
  src_e                  cdb_src_q;
  logic                  err_q;

  logic                  grant_alu, grant_lsb, grant_any;
  src_e                  grant_src;
  logic [WORD_WIDTH-1:0] grant_data;
  logic [TAG_WIDTH-1:0]  grant_tag;
  logic                  alu_ready, lsb_ready;
  logic                  alu_take, lsb_take;
  logic                  alu_null, lsb_null;

  always_comb begin
    grant_alu  = 1'b0;
    grant_lsb  = 1'b0;
    grant_src  = SRC_ALU;
    grant_data = alu_data_q;
    grant_tag  = alu_tag_q;

    // On a tie the source that did not broadcast last wins.
    if (alu_hv_q && lsb_hv_q) begin
      grant_alu = (last_q == SRC_LSB);
      grant_lsb = (last_q == SRC_ALU);
    end else begin
      grant_alu = alu_hv_q;
      grant_lsb = lsb_hv_q;
    end
    grant_any = grant_alu | grant_lsb;

    if (grant_lsb) begin
      grant_src  = SRC_LSB;
      grant_data = lsb_data_q;
      grant_tag  = lsb_tag_q;
    end

    alu_ready = rst & ~flush & (~alu_hv_q | grant_alu);
    lsb_ready = rst & ~flush & (~lsb_hv_q | grant_lsb);
    alu_take  = bus.alu_valid_in & alu_ready;
    lsb_take  = bus.lsb_valid_in & lsb_ready;
    alu_null  = (bus.alu_tag_in == '0);
    lsb_null  = (bus.lsb_tag_in == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_hv_q     <= 1'b0;
      lsb_hv_q     <= 1'b0;
      alu_data_q   <= '0;
      lsb_data_q   <= '0;
      alu_tag_q    <= '0;
      lsb_tag_q    <= '0;
      last_q       <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_tag_q    <= '0;
      cdb_src_q    <= SRC_ALU;
      err_q        <= 1'b0;
    end else if (flush) begin
      alu_hv_q    <= 1'b0;
      lsb_hv_q    <= 1'b0;
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        cdb_result_q <= grant_data;
        cdb_tag_q    <= grant_tag;
        cdb_src_q    <= grant_src;
        last_q       <= grant_src;
      end

      // A NULL-tag result is consumed but never occupies the holding register.
      if (alu_take && !alu_null) begin
        alu_hv_q   <= 1'b1;
        alu_data_q <= bus.alu_result_in;
        alu_tag_q  <= bus.alu_tag_in;
      end else if (grant_alu) begin
        alu_hv_q <= 1'b0;
      end

      if (lsb_take && !lsb_null) begin
        lsb_hv_q   <= 1'b1;
        lsb_data_q <= bus.lsb_result_in;
        lsb_tag_q  <= bus.lsb_tag_in;
      end else if (grant_lsb) begin
        lsb_hv_q <= 1'b0;
      end

      if ((alu_take && alu_null) || (lsb_take && lsb_null)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.alu_ready_out    = alu_ready;
  assign bus.lsb_ready_out    = lsb_ready;
  assign bus.cdb_valid_out    = cdb_valid_q;
  assign bus.cdb_result_out   = cdb_result_q;
  assign bus.cdb_tag_out      = cdb_tag_q;
  assign bus.cdb_src_out      = cdb_src_q;
  assign bus.err_null_tag_out = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a rule-level reference model.
module tb_cdb_arbiter;
  localparam int W = 32;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  cdb_arbiter_if #(.WORD_WIDTH(W), .TAG_WIDTH(T)) bus ();

  cdb_arbiter #(.WORD_WIDTH(W), .TAG_WIDTH(T)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [W-1:0] ad, input logic [T-1:0] at,
                       input logic lv, input logic [W-1:0] ld, input logic [T-1:0] lt,
                       input logic fl);
    bus.alu_valid_in  = av;
    bus.alu_result_in = ad;
    bus.alu_tag_in    = at;
    bus.lsb_valid_in  = lv;
    bus.lsb_result_in = ld;
    bus.lsb_tag_in    = lt;
    flush             = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    chk("rst alu_ready", bus.alu_ready_out, 0);
    chk("rst lsb_ready", bus.lsb_ready_out, 0);
    chk("rst cdb_valid", bus.cdb_valid_out, 0);
    chk("rst cdb_result", bus.cdb_result_out, 0);
    chk("rst cdb_tag", bus.cdb_tag_out, 0);
    chk("rst cdb_src", bus.cdb_src_out, 0);
    chk("rst err", bus.err_null_tag_out, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av; logic [T-1:0] at; logic [W-1:0] ad;
    logic lv; logic [T-1:0] lt; logic [W-1:0] ld;
    logic fl;
    logic e_ar; logic e_lr;
    logic e_v; logic [T-1:0] e_t; logic [W-1:0] e_d; logic e_s; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [T-1:0] at, input logic [W-1:0] ad,
                              input logic lv, input logic [T-1:0] lt, input logic [W-1:0] ld,
                              input logic fl, input logic e_ar, input logic e_lr,
                              input logic e_v, input logic [T-1:0] e_t, input logic [W-1:0] e_d,
                              input logic e_s, input logic e_err);
    vec_t v;
    v.av = av; v.at = at; v.ad = ad; v.lv = lv; v.lt = lt; v.ld = ld; v.fl = fl;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_v = e_v; v.e_t = e_t; v.e_d = e_d;
    v.e_s = e_s; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[14];

  task automatic run_table();
    // Readies are checked before the edge; CDB fields after it.
    vecs[0]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 0, 0, 'h00, 0, 0);
    vecs[1]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 0, 1, 1, 'h11, 0, 0);
    vecs[2]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 1, 2, 'h22, 1, 0);
    vecs[3]  = mk(1, 3, 'hAA, 0, 0, 'h00, 0, 1, 1, 0, 2, 'h22, 1, 0);
    vecs[4]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 1, 3, 'hAA, 0, 0);
    vecs[5]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 0, 3, 'hAA, 0, 0);
    vecs[6]  = mk(1, 4, 'h33, 1, 5, 'h44, 0, 1, 1, 0, 3, 'hAA, 0, 0);
    vecs[7]  = mk(1, 7, 'h77, 0, 0, 'h00, 1, 0, 0, 0, 3, 'hAA, 0, 0);
    vecs[8]  = mk(1, 7, 'h77, 0, 0, 'h00, 0, 1, 1, 0, 3, 'hAA, 0, 0);
    vecs[9]  = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 1, 7, 'h77, 0, 0);
    vecs[10] = mk(0, 0, 'h00, 1, 0, 'h55, 0, 1, 1, 0, 7, 'h77, 0, 1);
    vecs[11] = mk(0, 0, 'h00, 1, 5, 'h66, 0, 1, 1, 0, 7, 'h77, 0, 1);
    vecs[12] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 1, 5, 'h66, 1, 1);
    vecs[13] = mk(0, 0, 'h00, 0, 0, 'h00, 0, 1, 1, 0, 5, 'h66, 1, 1);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].av, vecs[i].ad, vecs[i].at, vecs[i].lv, vecs[i].ld, vecs[i].lt, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d alu_ready", i), bus.alu_ready_out, vecs[i].e_ar);
      chk($sformatf("vec%0d lsb_ready", i), bus.lsb_ready_out, vecs[i].e_lr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d cdb_valid", i), bus.cdb_valid_out, vecs[i].e_v);
      chk($sformatf("vec%0d cdb_tag", i), bus.cdb_tag_out, vecs[i].e_t);
      chk($sformatf("vec%0d cdb_result", i), bus.cdb_result_out, vecs[i].e_d);
      chk($sformatf("vec%0d cdb_src", i), bus.cdb_src_out, vecs[i].e_s);
      chk($sformatf("vec%0d err", i), bus.err_null_tag_out, vecs[i].e_err);
    end
    idle();
  endtask

  // ---------------- sustained contention ----------------
  task automatic run_contention();
    int alu_tags[3] = '{1, 3, 5};
    int lsb_tags[3] = '{2, 4, 6};
    int ai = 0;
    int li = 0;
    int got[$];
    logic ar, lr, av, lv;
    for (int c = 0; c < 20; c++) begin
      av = (ai < 3);
      lv = (li < 3);
      drive(av, av ? W'(alu_tags[ai] * 'h101) : '0, av ? T'(alu_tags[ai]) : '0,
            lv, lv ? W'(lsb_tags[li] * 'h101) : '0, lv ? T'(lsb_tags[li]) : '0, 1'b0);
      @(negedge clk);
      ar = bus.alu_ready_out;
      lr = bus.lsb_ready_out;
      @(posedge clk);
      #1;
      if (bus.cdb_valid_out === 1'b1) got.push_back(int'(bus.cdb_tag_out));
      if (av && ar) ai++;
      if (lv && lr) li++;
    end
    idle();
    chk("contention count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("contention tag%0d", i), got[i], i + 1);
  endtask

  // ---------------- asynchronous reset mid-stream ----------------
  task automatic run_async_reset();
    drive(1'b1, 'hA5, 4'd9, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
    chk("areset pre valid", bus.cdb_valid_out, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset valid", bus.cdb_valid_out, 0);
    chk("areset result", bus.cdb_result_out, 0);
    chk("areset tag", bus.cdb_tag_out, 0);
    chk("areset src", bus.cdb_src_out, 0);
    chk("areset err", bus.err_null_tag_out, 0);
    chk("areset alu_ready", bus.alu_ready_out, 0);
    chk("areset lsb_ready", bus.lsb_ready_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 'hB1, 4'd10, 1'b1, 'hB2, 4'd11, 1'b0);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
    chk("areset tie valid", bus.cdb_valid_out, 1);
    chk("areset tie src", bus.cdb_src_out, 0);
    chk("areset tie tag", bus.cdb_tag_out, 10);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic         pv[2];
  logic [W-1:0] pd[2];
  logic [T-1:0] pt[2];
  int           m_last;
  logic         m_v;
  logic [W-1:0] m_d;
  logic [T-1:0] m_t;
  logic         m_s;
  logic         m_err;

  logic [T+W-1:0] exp_q[2][$];

  logic         off_v[2];
  logic [W-1:0] off_d[2];
  logic [T-1:0] off_t[2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0; pd[s] = '0; pt[s] = '0;
      off_v[s] = 1'b0; off_d[s] = '0; off_t[s] = '0;
      exp_q[s].delete();
    end
    m_last = 1;
    m_v = 1'b0; m_d = '0; m_t = '0; m_s = 1'b0; m_err = 1'b0;
  endtask

  // Pending source that did not broadcast last; -1 when nothing is pending.
  function automatic int model_grant();
    if (pv[0] && pv[1]) return (m_last == 0) ? 1 : 0;
    if (pv[0]) return 0;
    if (pv[1]) return 1;
    return -1;
  endfunction

  task automatic rand_step(input bit allow_new);
    int g;
    logic fl;
    logic m_rdy[2];
    logic d_rdy[2];
    logic [T+W-1:0] e;
    int s;
    fl = allow_new && ($urandom_range(0, 19) == 0);
    drive(off_v[0], off_d[0], off_t[0], off_v[1], off_d[1], off_t[1], fl);
    @(negedge clk);
    g = model_grant();
    for (int k = 0; k < 2; k++) m_rdy[k] = !fl && (!pv[k] || g == k);
    d_rdy[0] = bus.alu_ready_out;
    d_rdy[1] = bus.lsb_ready_out;
    chk("rand alu_ready", d_rdy[0], m_rdy[0]);
    chk("rand lsb_ready", d_rdy[1], m_rdy[1]);

    if (fl) begin
      pv[0] = 1'b0; pv[1] = 1'b0; m_v = 1'b0;
      exp_q[0].delete(); exp_q[1].delete();
    end else begin
      m_v = (g >= 0);
      if (g >= 0) begin
        m_d = pd[g]; m_t = pt[g]; m_s = (g == 1); m_last = g; pv[g] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (off_v[k] && m_rdy[k]) begin
          if (off_t[k] == '0) m_err = 1'b1;
          else begin
            pv[k] = 1'b1; pd[k] = off_d[k]; pt[k] = off_t[k];
            exp_q[k].push_back({off_t[k], off_d[k]});
          end
        end
      end
    end

    @(posedge clk);
    #1;
    chk("rand cdb_valid", bus.cdb_valid_out, m_v);
    if (m_v) begin
      chk("rand cdb_result", bus.cdb_result_out, m_d);
      chk("rand cdb_tag", bus.cdb_tag_out, m_t);
      chk("rand cdb_src", bus.cdb_src_out, m_s);
    end
    chk("rand err", bus.err_null_tag_out, m_err);

    if (bus.cdb_valid_out === 1'b1) begin
      s = (bus.cdb_src_out === 1'b1) ? 1 : 0;
      chk("sb entry expected", exp_q[s].size() != 0, 1);
      if (exp_q[s].size() != 0) begin
        e = exp_q[s].pop_front();
        chk("sb broadcast", {bus.cdb_tag_out, bus.cdb_result_out}, e);
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (off_v[k] && d_rdy[k]) off_v[k] = 1'b0;
      if (allow_new && !off_v[k] && $urandom_range(0, 2) != 0) begin
        off_v[k] = 1'b1;
        off_d[k] = $urandom;
        off_t[k] = ($urandom_range(0, 9) == 0) ? '0 : T'($urandom_range(1, 15));
      end
    end
  endtask

  // ---------------- test sequence + report ----------------
  initial begin
    rst = 1'b0;
    idle();
    do_reset();
    run_table();
    do_reset();
    run_contention();
    do_reset();
    run_async_reset();
    do_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) rand_step(1'b1);
    for (int n = 0; n < 8; n++) rand_step(1'b0);
    chk("sb alu drained", exp_q[0].size(), 0);
    chk("sb lsb drained", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common-data-bus (CDB) broadcast port of the reorder buffer between the two result producers, the ALU and the load/store buffer. Each producer hands over results through a valid/ready handshake into a one-entry holding register. A round-robin arbiter drains the holding registers onto a registered CDB output at no more than one broadcast per cycle. The block sits between the ALU/LSB result ports and the ROB/reservation-station snoop inputs, and guarantees that the two producers never drive the bus in the same cycle.

## Interface
- `WORD_WIDTH`, 32, result data width
- `TAG_WIDTH`, 4, ROB tag width; tag 0 is the NULL tag
- `clk` input 1: system clock, rising edge
- `rst` input 1: reset, asynchronous, active-low
- `flush` input 1: synchronous pipeline flush (mispredict); discards all pending results
- `alu_valid_in` input 1: ALU offers a result this cycle
- `alu_result_in` input WORD_WIDTH: ALU result
- `alu_tag_in` input TAG_WIDTH: destination ROB tag of the ALU result
- `alu_ready_out` output 1: arbiter accepts the ALU result at the next edge
- `lsb_valid_in` input 1: LSB offers a result this cycle
- `lsb_result_in` input WORD_WIDTH: LSB result
- `lsb_tag_in` input TAG_WIDTH: destination ROB tag of the LSB result
- `lsb_ready_out` output 1: arbiter accepts the LSB result at the next edge
- `cdb_valid_out` output 1: broadcast valid (registered)
- `cdb_result_out` output WORD_WIDTH: broadcast data (registered)
- `cdb_tag_out` output TAG_WIDTH: broadcast ROB tag (registered)
- `cdb_src_out` output 1: source of the broadcast, 0 = ALU, 1 = LSB (registered)
- `err_null_tag_out` output 1: sticky flag; a NULL-tag result was offered

## Operation
- State per requester: a holding register {`hv`, data, tag}. Global state: a round-robin pointer `last`, plus the CDB output registers.
- Handshake: a transfer occurs at the edge where valid and ready are both 1.
  - `X_ready_out = rst & !flush & (!hv_X | grant_X)`. It is combinational and does not depend on `X_valid_in`.
  - A requester holds valid, result and tag stable until it sees the transfer.
- Grant, combinational:
  - Only `hv_ALU` set: grant ALU.
  - Only `hv_LSB` set: grant LSB.
  - Both set: grant the source not equal to `last` (ALU when `last` = LSB).
  - Neither set: no grant.
- At each edge, when neither `flush` nor reset is active:
  - Grant present: CDB registers load the granted hold contents; `cdb_valid_out` <= 1; `cdb_src_out` <= source; `last` <= source.
  - No grant: `cdb_valid_out` <= 0. Result, tag and src hold their previous values.
  - A granted hold clears unless refilled at the same edge. Drain and refill at the same edge are legal, giving full throughput of one result per requester every other cycle under contention and one per cycle when uncontended.
  - An accepted input with tag 0 is consumed (ready is honoured) but not stored. `err_null_tag_out` <= 1 and stays set until reset.
- `flush` at the edge:
  - Both `hv` <= 0 and `cdb_valid_out` <= 0.
  - Inputs offered in the flush cycle are not accepted (ready is 0).
  - `last` is unchanged.
- Starvation bound: a held result is broadcast within 2 cycles of entering its holding register.

## Timing
- Reset (`rst` low, asynchronous):
  - `cdb_valid_out` = 0, `cdb_result_out` = 0, `cdb_tag_out` = 0, `cdb_src_out` = 0, `err_null_tag_out` = 0.
  - Both `hv` = 0; `last` = LSB, so the ALU wins the first tie.
  - Both ready outputs are 0 while `rst` is low.
- Reset assertion mid-operation discards held results and any in-flight broadcast immediately, without waiting for a clock edge.
- Latency: result accepted at edge E0; earliest broadcast is `cdb_valid_out` high in the cycle after edge E0+1.
- Under contention the loser broadcasts one cycle after the winner.
- `cdb_valid_out` is high for exactly one cycle per accepted non-NULL result. No duplicates and no losses, except on `flush` or reset.
- Back-to-back: `cdb_valid_out` may stay high on consecutive cycles with different tags.

## Test plan
- Single ALU result: ALU offers {0x0000_00AA, tag 3} at edge 1 → `alu_ready_out` = 1; after edge 2, `cdb_valid_out` = 1, result 0xAA, tag 3, src 0, for one cycle only.
- Simultaneous: ALU {0x11, tag 1} and LSB {0x22, tag 2} both accepted at edge 1 → after edge 2 broadcast tag 1 (ALU); after edge 3 broadcast tag 2 (LSB); `lsb_ready_out` = 0 during the cycle before edge 2.
- Sustained contention: both requesters hold valid continuously with tags 1..6 (ALU odd, LSB even) → CDB tags alternate strictly, with no tag lost or repeated.
- Flush: results held in both registers, `flush` pulsed for one cycle → no broadcast follows; both readies are 0 in the flush cycle and 1 the cycle after.
- NULL tag: LSB offers {0x55, tag 0} → accepted, no broadcast, `err_null_tag_out` = 1 and sticky; a subsequent tag 5 result still broadcasts normally.
- Async reset mid-stream: drop `rst` between edges while `cdb_valid_out` = 1 → all outputs are 0 immediately; after release, the first tie is granted to the ALU.
